// File: rtl/sirv_spi_slave_byte_if.sv
// -----------------------------------------------------------------------------
// sirv_spi_slave_byte_if
// Byte-stream bundle between the SPI slave and the logic that consumes received
// bytes and supplies bytes to transmit.
//   io_rx_valid / io_rx_ready / io_rx_bits[7:0] : received bytes, slave -> user
//   io_tx_valid / io_tx_ready / io_tx_bits[7:0] : bytes to send, user -> slave
// Modport slave is used by the SPI block and modport master by the user side.
// -----------------------------------------------------------------------------
interface sirv_spi_slave_byte_if;
   logic       io_rx_valid;
   logic       io_rx_ready;
   logic [7:0] io_rx_bits;
   logic       io_tx_valid;
   logic       io_tx_ready;
   logic [7:0] io_tx_bits;

   modport slave (
      output io_rx_valid,
      output io_rx_bits,
      output io_tx_ready,
      input  io_rx_ready,
      input  io_tx_valid,
      input  io_tx_bits
   );

   modport master (
      input  io_rx_valid,
      input  io_rx_bits,
      input  io_tx_ready,
      output io_rx_ready,
      output io_tx_valid,
      output io_tx_bits
   );
endinterface

// File: rtl/sirv_spi_slave_byte.sv
// -----------------------------------------------------------------------------
// sirv_spi_slave_byte
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) byte slave, oversampled by the system
// clock. sck, cs and mosi are resynchronised, edges are detected in the clock
// domain, and bytes are exchanged through a ready/valid stream pair.
// Ports:
//   clock, reset         : system clock, synchronous active-high reset
//   io_port_sck/cs/mosi  : asynchronous SPI inputs (cs active low)
//   io_port_miso_o/_oe   : serial data to the master and its output enable
//   bus (slave modport)  : rx byte stream out, tx byte stream in
//   io_overrun           : sticky, a received byte was dropped
//   io_ovr_clr           : one-cycle pulse clearing io_overrun
//   io_busy              : synchronised chip select is asserted
// -----------------------------------------------------------------------------
module sirv_spi_slave_byte #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        io_port_sck,
   input  logic                        io_port_cs,
   input  logic                        io_port_mosi,
   output logic                        io_port_miso_o,
   output logic                        io_port_miso_oe,
   sirv_spi_slave_byte_if.slave        bus,
   output logic                        io_overrun,
   input  logic                        io_ovr_clr,
   output logic                        io_busy
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] flush_q;
   logic                   sck_dly_q;
   logic                   cs_dly_q;
   logic                   armed_q;

   state_t                 state_q;
   logic [2:0]             bit_cnt_q;
   logic [7:0]             rx_shift_q;
   logic [7:0]             tx_shift_q;
   logic                   miso_oe_q;
   logic                   rx_valid_q;
   logic [7:0]             rx_bits_q;
   logic                   overrun_q;

   logic                   sck_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sck_rise;
   logic                   sck_fall;
   logic                   cs_fall;
   logic                   stay_active;
   logic                   tx_load;
   logic [7:0]             tx_load_byte;
   logic                   rx_done;
   logic [7:0]             rx_byte;
   logic                   rx_hs;

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign sck_rise = sck_s & ~sck_dly_q;
   assign sck_fall = ~sck_s & sck_dly_q;

   // The synchroniser restarts at the idle level after reset, so a cs that is
   // already low would otherwise look like a fresh falling edge. armed_q only
   // opens once the pipeline has flushed and cs has really been seen high.
   assign cs_fall = armed_q & cs_dly_q & ~cs_s;

   assign stay_active  = (state_q == ST_ACTIVE) && !cs_s;
   assign tx_load      = !reset && (((state_q == ST_IDLE) && cs_fall) ||
                                    (stay_active && sck_fall && (bit_cnt_q == 3'd0)));
   assign tx_load_byte = bus.io_tx_valid ? bus.io_tx_bits : IDLE_BYTE;

   assign rx_byte = {rx_shift_q[6:0], mosi_s};
   assign rx_done = stay_active && sck_rise && (bit_cnt_q == 3'd7);
   assign rx_hs   = rx_valid_q && bus.io_rx_ready;

   assign bus.io_tx_ready = tx_load;
   assign bus.io_rx_valid = rx_valid_q;
   assign bus.io_rx_bits  = rx_bits_q;
   assign io_overrun      = overrun_q;
   assign io_busy         = ~cs_s;
   assign io_port_miso_oe = miso_oe_q;
   assign io_port_miso_o  = (state_q == ST_ACTIVE) ? tx_shift_q[7] : 1'b0;

   // Input synchronisers, edge-detect delay taps and the post-reset arming flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         sck_sync_q  <= {SYNC_STAGES{1'b0}};
         cs_sync_q   <= {SYNC_STAGES{1'b1}};
         mosi_sync_q <= {SYNC_STAGES{1'b0}};
         flush_q     <= {SYNC_STAGES{1'b0}};
         sck_dly_q   <= 1'b0;
         cs_dly_q    <= 1'b1;
         armed_q     <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], io_port_sck};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], io_port_cs};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], io_port_mosi};
         flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
         sck_dly_q   <= sck_s;
         cs_dly_q    <= cs_s;
         if (flush_q[SYNC_STAGES-1] && cs_s) begin
            armed_q <= 1'b1;
         end else begin
            armed_q <= armed_q;
         end
      end
   end

   // Frame FSM with the bit counter, shift registers and miso enable.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         rx_shift_q <= 8'h00;
         tx_shift_q <= IDLE_BYTE;
         miso_oe_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_q    <= ST_ACTIVE;
                  bit_cnt_q  <= 3'd0;
                  miso_oe_q  <= 1'b1;
                  tx_shift_q <= tx_load_byte;
               end else begin
                  miso_oe_q  <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (cs_s) begin
                  // cs released: any partial byte is thrown away.
                  state_q    <= ST_IDLE;
                  bit_cnt_q  <= 3'd0;
                  rx_shift_q <= 8'h00;
                  miso_oe_q  <= 1'b0;
               end else if (sck_rise) begin
                  rx_shift_q <= rx_byte;
                  bit_cnt_q  <= bit_cnt_q + 3'd1;
               end else if (sck_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     tx_shift_q <= tx_load_byte;
                  end else begin
                     tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                  end
               end else begin
                  state_q <= ST_ACTIVE;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               bit_cnt_q  <= 3'd0;
               rx_shift_q <= 8'h00;
               miso_oe_q  <= 1'b0;
            end
         endcase
      end
   end

   // Rx holding register and the sticky overrun flag (set beats clear).
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_valid_q <= 1'b0;
         rx_bits_q  <= 8'h00;
         overrun_q  <= 1'b0;
      end else begin
         if (rx_done) begin
            if (!rx_valid_q || bus.io_rx_ready) begin
               rx_bits_q  <= rx_byte;
               rx_valid_q <= 1'b1;
            end else begin
               rx_valid_q <= 1'b1;
            end
         end else if (rx_hs) begin
            rx_valid_q <= 1'b0;
         end else begin
            rx_valid_q <= rx_valid_q;
         end

         if (rx_done && rx_valid_q && !bus.io_rx_ready) begin
            overrun_q <= 1'b1;
         end else if (io_ovr_clr) begin
            overrun_q <= 1'b0;
         end else begin
            overrun_q <= overrun_q;
         end
      end
   end

endmodule

// File: tb/tb_sirv_spi_slave_byte.sv
// -----------------------------------------------------------------------------
// tb_sirv_spi_slave_byte
// Directed bench for sirv_spi_slave_byte. Inputs change 1 time unit after a
// rising clock edge; outputs are observed on the falling edge. Expected rx
// bytes are queued when a frame is sent and popped by a monitor on each
// rx handshake.
// -----------------------------------------------------------------------------
module tb_sirv_spi_slave_byte;

   logic clock = 1'b0;
   logic reset;
   logic sck;
   logic cs;
   logic mosi;
   logic miso_o;
   logic miso_oe;
   logic overrun;
   logic ovr_clr;
   logic busy;

   int errors = 0;
   int checks = 0;
   int tx_hs = 0;
   int valid_cycles = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mi0;
   logic [7:0] mi1;

   sirv_spi_slave_byte_if bus();

   sirv_spi_slave_byte #(
      .SYNC_STAGES (2),
      .IDLE_BYTE   (8'hFF)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .io_port_sck     (sck),
      .io_port_cs      (cs),
      .io_port_mosi    (mosi),
      .io_port_miso_o  (miso_o),
      .io_port_miso_oe (miso_oe),
      .bus             (bus),
      .io_overrun      (overrun),
      .io_ovr_clr      (ovr_clr),
      .io_busy         (busy)
   );

   always #5 clock = ~clock;

   // Monitor: rx scoreboard, tx handshake count, rx_valid cycle count.
   always @(negedge clock) begin
      if (bus.io_tx_ready && bus.io_tx_valid) tx_hs++;
      if (bus.io_rx_valid) valid_cycles++;
      if (!reset && bus.io_rx_valid && bus.io_rx_ready) begin
         logic [7:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected: got %02h, required no byte", bus.io_rx_bits);
         end else begin
            e = exp_q.pop_front();
            if (bus.io_rx_bits !== e) begin
               errors++;
               $display("FAIL rx_byte: got %02h, required %02h", bus.io_rx_bits, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic cs_low();
      cs = 1'b0;
      cycles(6);
   endtask

   task automatic cs_high();
      cycles(4);
      cs = 1'b1;
      cycles(8);
   endtask

   // Clock out the top nbits of mo at sck = clock/8, capturing miso before
   // each rising sck. rdy_last raises rx_ready in the cycle the last rising
   // edge is detected inside the DUT.
   task automatic xfer(input logic [7:0] mo, input int nbits, input bit rdy_last,
                       output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = mo[7-i];
         cycles(4);
         mi = {mi[6:0], miso_o};
         sck = 1'b1;
         if (rdy_last && (i == nbits - 1)) begin
            cycles(2);
            bus.io_rx_ready = 1'b1;
            cycles(2);
         end else begin
            cycles(4);
         end
         sck = 1'b0;
      end
   endtask

   task automatic wait_empty();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         cycles(1);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rx_timeout: %0d bytes outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_valid"}, {31'd0, bus.io_rx_valid}, 32'd0);
      check({tag, "_overrun"},  {31'd0, overrun},          32'd0);
      check({tag, "_busy"},     {31'd0, busy},             32'd0);
      check({tag, "_miso"},     {31'd0, miso_o},           32'd0);
      check({tag, "_miso_oe"},  {31'd0, miso_oe},          32'd0);
      check({tag, "_tx_ready"}, {31'd0, bus.io_tx_ready},  32'd0);
      check({tag, "_rx_bits"},  {24'd0, bus.io_rx_bits},   32'd0);
   endtask

   initial begin
      reset = 1'b1;
      sck = 1'b0;
      cs = 1'b1;
      mosi = 1'b0;
      ovr_clr = 1'b0;
      bus.io_rx_ready = 1'b1;
      bus.io_tx_valid = 1'b0;
      bus.io_tx_bits = 8'h00;
      cycles(3);
      check_reset_outputs("init");
      reset = 1'b0;
      cycles(10);

      // Single byte A5, consumer always ready, no tx byte offered.
      valid_cycles = 0;
      exp_q.push_back(8'hA5);
      cs_low();
      check("busy_active", {31'd0, busy}, 32'd1);
      check("oe_active", {31'd0, miso_oe}, 32'd1);
      xfer(8'hA5, 8, 1'b0, mi0);
      cs_high();
      wait_empty();
      check("a5_valid_cycles", valid_cycles, 32'd1);
      check("a5_overrun", {31'd0, overrun}, 32'd0);
      check("a5_miso_idle", {24'd0, mi0}, 32'h0000_00FF);

      // Tx byte 3C offered before the frame, 16 bits clocked.
      tx_hs = 0;
      bus.io_tx_bits = 8'h3C;
      bus.io_tx_valid = 1'b1;
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
      cs_low();
      bus.io_tx_valid = 1'b0;
      xfer(8'h12, 8, 1'b0, mi0);
      xfer(8'h34, 8, 1'b0, mi1);
      cs_high();
      wait_empty();
      check("tx_byte0", {24'd0, mi0}, 32'h0000_003C);
      check("tx_byte1", {24'd0, mi1}, 32'h0000_00FF);
      check("tx_handshakes", tx_hs, 32'd1);

      // Overrun: consumer stalled, 11 then 22.
      bus.io_rx_ready = 1'b0;
      exp_q.push_back(8'h11);
      cs_low();
      xfer(8'h11, 8, 1'b0, mi0);
      xfer(8'h22, 8, 1'b0, mi0);
      cs_high();
      check("ovr_valid", {31'd0, bus.io_rx_valid}, 32'd1);
      check("ovr_bits_kept", {24'd0, bus.io_rx_bits}, 32'h0000_0011);
      check("ovr_set", {31'd0, overrun}, 32'd1);
      ovr_clr = 1'b1;
      cycles(1);
      ovr_clr = 1'b0;
      cycles(1);
      check("ovr_cleared", {31'd0, overrun}, 32'd0);
      bus.io_rx_ready = 1'b1;
      wait_empty();
      bus.io_rx_ready = 1'b0;
      cycles(2);

      // Ready raised in the very cycle the second byte completes.
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h22);
      cs_low();
      xfer(8'h33, 8, 1'b0, mi0);
      xfer(8'h22, 8, 1'b1, mi0);
      cs_high();
      wait_empty();
      check("same_cycle_overrun", {31'd0, overrun}, 32'd0);

      // cs dropped after 5 bits, then a clean 81 frame.
      bus.io_rx_ready = 1'b1;
      cs_low();
      xfer(8'hF7, 5, 1'b0, mi0);
      cs_high();
      check("abort_oe", {31'd0, miso_oe}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_miso", {31'd0, miso_o}, 32'd0);
      exp_q.push_back(8'h81);
      cs_low();
      xfer(8'h81, 8, 1'b0, mi0);
      cs_high();
      wait_empty();

      // Leave a pending byte and overrun, then reset mid-frame.
      bus.io_rx_ready = 1'b0;
      cs_low();
      xfer(8'h77, 8, 1'b0, mi0);
      xfer(8'h66, 8, 1'b0, mi0);
      check("pre_reset_overrun", {31'd0, overrun}, 32'd1);
      xfer(8'hE0, 3, 1'b0, mi0);
      reset = 1'b1;
      cycles(1);
      check_reset_outputs("midrst");
      cycles(1);
      reset = 1'b0;
      cycles(2);
      check("post_reset_idle", {31'd0, miso_oe}, 32'd0);
      cs = 1'b1;
      cycles(10);
      bus.io_rx_ready = 1'b1;
      exp_q.push_back(8'h5A);
      cs_low();
      xfer(8'h5A, 8, 1'b0, mi0);
      cs_high();
      wait_empty();
      check("post_reset_overrun", {31'd0, overrun}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sirv_spi_slave_byte.md
SIRV_SPI_SLAVE_BYTE -- requirements
Module: sirv_spi_slave_byte

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the synchroniser on each of sck, cs and mosi; legal values are 2 or more.
REQ-002 Parameter IDLE_BYTE, default 8'hFF: byte shifted out on miso when no tx byte is available.
REQ-003 Port clock, in, 1: the single system clock; all logic is on its rising edge.
REQ-004 Port reset, in, 1: synchronous, active-high reset.
REQ-005 Port io_port_sck, in, 1: SPI clock from the master, asynchronous to clock.
REQ-006 Port io_port_cs, in, 1: chip select, active low, asynchronous.
REQ-007 Port io_port_mosi, in, 1: serial data from the master, asynchronous.
REQ-008 Port io_port_miso_o, out, 1: serial data to the master.
REQ-009 Port io_port_miso_oe, out, 1: output enable for miso.
REQ-010 Port io_rx_valid, out, 1 / io_rx_ready, in, 1 / io_rx_bits, out, 8: received-byte stream.
REQ-011 Port io_tx_valid, in, 1 / io_tx_ready, out, 1 / io_tx_bits, in, 8: byte-to-transmit stream.
REQ-012 Port io_overrun, out, 1: sticky flag, set when a received byte is lost.
REQ-013 Port io_ovr_clr, in, 1: one-cycle pulse that clears io_overrun.
REQ-014 Port io_busy, out, 1: high while the synchronised chip select is asserted.

Function
REQ-015 sck, cs and mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected by comparing the last synchroniser stage with a one-cycle-delayed copy.
REQ-016 SPI mode is 0 (CPOL=0, CPHA=0), MSB first; mosi SHALL be sampled on a synchronised sck rising edge and miso SHALL change on a synchronised sck falling edge.
REQ-017 The supported sck frequency is at most clock/4; rising and falling edges SHALL never be detected in the same cycle.
REQ-018 FSM states: IDLE and ACTIVE; IDLE to ACTIVE on the synchronised cs falling edge; ACTIVE to IDLE on the synchronised cs going high.
REQ-019 On IDLE to ACTIVE: bit_cnt SHALL be set to 0, a tx load event SHALL occur, and miso_oe SHALL be set to 1.
REQ-020 Tx load event: io_tx_ready SHALL be 1 combinationally for that cycle only.
REQ-021 During a tx load event, tx_shift SHALL load io_tx_bits if io_tx_valid is 1, otherwise IDLE_BYTE; the byte is consumed only when io_tx_valid is 1.
REQ-022 io_tx_ready SHALL be 0 in all other cycles.
REQ-023 io_port_miso_o SHALL equal tx_shift[7] while ACTIVE and 0 while IDLE.
REQ-024 On each rising edge in ACTIVE: rx_shift SHALL be updated to {rx_shift[6:0], mosi_sync} and bit_cnt SHALL be incremented by 1, modulo 8.
REQ-025 When a rising edge takes bit_cnt from 7 to 0, the completed byte SHALL be offered to the rx holding register.
REQ-026 On each falling edge in ACTIVE: if bit_cnt==0 a tx load event SHALL occur, else tx_shift SHALL shift left by one bit.
REQ-027 Completed byte, holding register empty or rx handshake occurring in the same cycle: io_rx_bits SHALL be loaded and io_rx_valid SHALL be 1 from the next cycle.
REQ-028 Completed byte, io_rx_valid=1 and io_rx_ready=0: the new byte SHALL be dropped, io_rx_bits SHALL keep the old byte, and io_overrun SHALL be set.
REQ-029 A handshake (io_rx_valid and io_rx_ready both 1) with no completion in that cycle SHALL clear io_rx_valid next cycle.
REQ-030 io_rx_bits SHALL be stable while io_rx_valid=1.
REQ-031 io_ovr_clr SHALL clear io_overrun; if a set and a clear occur in the same cycle, set SHALL win.
REQ-032 cs deasserted mid-byte: the partial rx byte SHALL be discarded, bit_cnt SHALL be set to 0, and miso_oe and miso_o SHALL be 0.
REQ-033 A pending io_rx_valid byte SHALL be retained across cs deassertion.
REQ-034 sck edges detected while IDLE SHALL be ignored.
REQ-035 Latency: io_rx_valid SHALL rise exactly one cycle after the cycle in which the 8th rising edge is detected.

Reset
REQ-036 While reset=1, the FSM SHALL be in IDLE and every synchroniser flop SHALL be set to its idle level (sck 0, cs 1, mosi 0).
REQ-037 While reset=1, bit_cnt, rx_shift and io_rx_bits SHALL be 0, and tx_shift SHALL be IDLE_BYTE.
REQ-038 While reset=1, outputs SHALL be: io_rx_valid=0, io_overrun=0, io_busy=0, io_port_miso_o=0, io_port_miso_oe=0, io_tx_ready=0.
REQ-039 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL wait for a fresh cs falling edge.

Verification
REQ-040 Bench: cs low, master sends 8'hA5 at sck=clock/8, io_rx_ready=1 -> io_rx_bits=8'hA5 and io_rx_valid high for 1 cycle, io_overrun=0.
REQ-041 Bench: io_tx_valid=1 with io_tx_bits=8'h3C before cs falls; master clocks 16 bits; no second tx byte -> miso carries 3C then FF; io_tx_ready pulses once with valid.
REQ-042 Bench: io_rx_ready=0, master sends 8'h11 then 8'h22 -> io_rx_bits stays 8'h11 and io_overrun=1; io_ovr_clr pulse -> io_overrun=0.
REQ-043 Bench: io_rx_ready asserted in the same cycle the second byte completes -> io_rx_bits=8'h22 next cycle and io_overrun stays 0.
REQ-044 Bench: cs deasserted after 5 bits, then a new frame of 8'h81 -> only 8'h81 is received; miso_oe=0 while cs is high.
REQ-045 Bench: reset pulsed mid-frame -> all outputs equal the reset values of REQ-038; the next full frame of 8'h5A is received correctly.
